mil_bc_sequencer: RTL and testbench

//  Bus-controller transaction sequencer for one MIL-STD-1553 bus. Takes one command
//  (BC->RT or RT->BC) and feeds command/data words to the Manchester transmitter.

---
 rtl/milStd1553.sv | 56 +++++
 rtl/mil_response_timer.sv | 35 +++
 rtl/mil_bc_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mil_bc_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/milStd1553.sv
`default_nettype none
// ============================================================================
//  Module      : milStd1553 (package)
//  Description : Shared MIL-STD-1553 word types, command word layout,
//                transaction result codes and small decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package milStd1553;

   // Word classification shared by the Manchester transmitter and receiver
   typedef enum logic [1:0] {
      WSTATUS  = 2'd0,
      WCOMMAND = 2'd1,
      WDATA    = 2'd2,
      WERROR   = 2'd3
   } MilType;

   // Outcome of one bus-controller transaction
   typedef enum logic [2:0] {
      TR_OK         = 3'd0,
      TR_TIMEOUT    = 3'd1,
      TR_BADADDR    = 3'd2,
      TR_BADSTATUS  = 3'd3,
      TR_PARITY     = 3'd4,
      TR_UNEXPECTED = 3'd5,
      TR_UNDERFLOW  = 3'd6
   } MilTrResult;

   // Command word field layout
   typedef struct packed {
      logic [4:0] rt_addr;
      logic       rt2bc;     // 1 = RT transmits to BC
      logic [4:0] subaddr;
      logic [4:0] count;     // 0 encodes 32 words
   } MilCmd;

   // Number of data words a command moves; mode codes (subaddr 0/31) move none
   function automatic logic [5:0] cmd_word_count(input logic [4:0] subaddr,
                                                 input logic [4:0] count);
      if (subaddr == 5'd0 || subaddr == 5'd31) begin
         return 6'd0;
      end
      if (count == 5'd0) begin
         return 6'd32;
      end
      return {1'b0, count};
   endfunction

   // The first error seen in a transaction is the one that is reported
   function automatic MilTrResult tr_first_error(input MilTrResult acc,
                                                 input MilTrResult code);
      return (acc == TR_OK) ? code : acc;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mil_response_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mil_response_timer
//  Description : Loadable down-counter used for RT response and inter-word
//                gap timeouts. Stops at zero; expired is high while zero.
//  Revision    : 1.0  initial release
// ============================================================================
module mil_response_timer #(
   parameter int CNT_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             run,
   output logic             expired
);

   logic [CNT_W-1:0] r_cnt;

   // Load has priority; otherwise count down while running, saturating at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (run && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mil_bc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mil_bc_sequencer
//  Description : MIL-STD-1553 bus-controller transaction sequencer. Sends one
//                command (plus BC->RT data), gates the receiver, checks the
//                RT status and RT->BC data words, reports one result.
//  Revision    : 1.0  initial release
// ============================================================================
module mil_bc_sequencer
   import milStd1553::*;
#(
   parameter int RESP_TIMEOUT = 1400,
   parameter int GAP_TIMEOUT  = 400,
   parameter int CNT_W        = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_word,
   input  logic        txd_valid,
   output logic        txd_ready,
   input  logic [15:0] txd_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [15:0] tx_word,
   output logic [1:0]  tx_type,
   input  logic        tx_idle,
   output logic        rx_enable,
   input  logic        rx_req,
   input  logic [15:0] rx_word,
   input  logic [1:0]  rx_type,
   output logic        rxd_valid,
   output logic [15:0] rxd_data,
   output logic        done,
   output logic [2:0]  result,
   output logic [15:0] status,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_SEND_CMD    = 3'd1,
      S_SEND_DATA   = 3'd2,
      S_WAIT_TXIDLE = 3'd3,
      S_WAIT_STATUS = 3'd4,
      S_RECV_DATA   = 3'd5,
      S_FINISH      = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] c_resp_load = CNT_W'(RESP_TIMEOUT);
   localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'(GAP_TIMEOUT);

   state_t      r_state;
   logic [15:0] r_cmd;
   logic [4:0]  r_addr;
   logic        r_rt2bc;
   logic [5:0]  r_wc;
   logic [5:0]  r_cnt;
   logic        r_tx_valid;
   logic        r_rx_enable;
   logic        r_rxd_valid;
   logic [15:0] r_rxd_data;
   logic        r_done;
   MilTrResult  r_result;
   MilTrResult  r_res_acc;
   logic [15:0] r_status;
   logic        r_skip_status;

   MilCmd       w_in_cmd;
   MilType      w_rx_type;
   logic        w_rx_is_stat;
   logic [5:0]  w_cnt_inc;
   logic        w_tmr_load;
   logic [CNT_W-1:0] w_tmr_val;
   logic        w_tmr_run;
   logic        w_tmr_expired;
   logic        w_fin;
   MilTrResult  w_err_code;

   assign w_in_cmd     = MilCmd'(cmd_word);
   assign w_rx_type    = MilType'(rx_type);
   // A status word with bit 9 set is indistinguishable from a command word
   assign w_rx_is_stat = (w_rx_type == WSTATUS) || (w_rx_type == WCOMMAND);
   assign w_cnt_inc    = r_cnt + 6'd1;

   // Response timer: loaded once the line goes quiet, reloaded on every received word
   assign w_tmr_load = ((r_state == S_WAIT_TXIDLE) && tx_idle && !r_skip_status) ||
                       (((r_state == S_WAIT_STATUS) || (r_state == S_RECV_DATA)) && rx_req);
   assign w_tmr_val  = (r_state == S_WAIT_TXIDLE) ? c_resp_load : c_gap_load;
   assign w_tmr_run  = (r_state == S_WAIT_STATUS) || (r_state == S_RECV_DATA);

   mil_response_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .run      (w_tmr_run),
      .expired  (w_tmr_expired)
   );

   // Transmit path: data words stream straight from the source while in the data phase
   assign tx_valid  = r_tx_valid && ((r_state != S_SEND_DATA) || txd_valid);
   assign tx_word   = (r_state == S_SEND_DATA) ? txd_data : r_cmd;
   assign tx_type   = (r_state == S_SEND_DATA) ? WDATA : WCOMMAND;
   assign txd_ready = (r_state == S_SEND_DATA) && tx_valid && tx_ready;

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign rx_enable = r_rx_enable;
   assign rxd_valid = r_rxd_valid;
   assign rxd_data  = r_rxd_data;
   assign done      = r_done;
   assign result    = r_result;
   assign status    = r_status;

   // Error detection and finish decision for the current cycle; rx_req beats expiry
   always_comb begin
      w_fin      = 1'b0;
      w_err_code = TR_OK;
      case (r_state)
         S_SEND_DATA: begin
            if (!txd_valid) begin
               w_err_code = TR_UNDERFLOW;
            end
         end
         S_WAIT_TXIDLE: begin
            w_fin = tx_idle && r_skip_status;
         end
         S_WAIT_STATUS: begin
            if (rx_req) begin
               if (w_rx_is_stat) begin
                  if (rx_word[15:11] != r_addr) begin
                     w_err_code = TR_BADADDR;
                     w_fin      = 1'b1;
                  end else begin
                     if (rx_word[10:0] != 11'd0) begin
                        w_err_code = TR_BADSTATUS;
                     end
                     w_fin = !(r_rt2bc && (r_wc != 6'd0));
                  end
               end else if (w_rx_type == WERROR) begin
                  w_err_code = TR_PARITY;
                  w_fin      = 1'b1;
               end else begin
                  w_err_code = TR_UNEXPECTED;
                  w_fin      = 1'b1;
               end
            end else if (w_tmr_expired) begin
               w_err_code = TR_TIMEOUT;
               w_fin      = 1'b1;
            end
         end
         S_RECV_DATA: begin
            if (rx_req) begin
               if (w_rx_type == WDATA) begin
                  w_fin = (w_cnt_inc == r_wc);
               end else if (w_rx_type == WERROR) begin
                  w_err_code = TR_PARITY;
                  w_fin      = 1'b1;
               end else begin
                  w_err_code = TR_UNEXPECTED;
                  w_fin      = 1'b1;
               end
            end else if (w_tmr_expired) begin
               w_err_code = TR_TIMEOUT;
               w_fin      = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Transaction state machine with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cmd         <= 16'h0000;
         r_addr        <= 5'd0;
         r_rt2bc       <= 1'b0;
         r_wc          <= 6'd0;
         r_cnt         <= 6'd0;
         r_tx_valid    <= 1'b0;
         r_rx_enable   <= 1'b0;
         r_rxd_valid   <= 1'b0;
         r_rxd_data    <= 16'h0000;
         r_done        <= 1'b0;
         r_result      <= TR_OK;
         r_res_acc     <= TR_OK;
         r_status      <= 16'h0000;
         r_skip_status <= 1'b0;
      end else begin
         r_done      <= 1'b0;
         r_rxd_valid <= 1'b0;
         if (w_err_code != TR_OK) begin
            r_res_acc <= tr_first_error(r_res_acc, w_err_code);
         end
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_cmd         <= cmd_word;
                  r_addr        <= w_in_cmd.rt_addr;
                  r_rt2bc       <= w_in_cmd.rt2bc;
                  r_wc          <= cmd_word_count(w_in_cmd.subaddr, w_in_cmd.count);
                  r_cnt         <= 6'd0;
                  r_res_acc     <= TR_OK;
                  r_skip_status <= 1'b0;
                  r_tx_valid    <= 1'b1;
                  r_state       <= S_SEND_CMD;
               end
            end
            S_SEND_CMD: begin
               if (tx_ready) begin
                  if (!r_rt2bc && (r_wc != 6'd0)) begin
                     r_state <= S_SEND_DATA;
                  end else begin
                     r_tx_valid <= 1'b0;
                     r_state    <= S_WAIT_TXIDLE;
                  end
               end
            end
            S_SEND_DATA: begin
               if (!txd_valid) begin
                  r_skip_status <= 1'b1;
                  r_tx_valid    <= 1'b0;
                  r_state       <= S_WAIT_TXIDLE;
               end else if (tx_ready) begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == r_wc) begin
                     r_tx_valid <= 1'b0;
                     r_state    <= S_WAIT_TXIDLE;
                  end
               end
            end
            S_WAIT_TXIDLE: begin
               if (tx_idle && !r_skip_status) begin
                  r_cnt       <= 6'd0;
                  r_rx_enable <= 1'b1;
                  r_state     <= S_WAIT_STATUS;
               end
            end
            S_WAIT_STATUS: begin
               if (rx_req && w_rx_is_stat) begin
                  r_status <= rx_word;
                  r_state  <= S_RECV_DATA;
               end
            end
            S_RECV_DATA: begin
               if (rx_req && (w_rx_type == WDATA)) begin
                  r_rxd_valid <= 1'b1;
                  r_rxd_data  <= rx_word;
                  r_cnt       <= w_cnt_inc;
               end
            end
            S_FINISH: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
         if (w_fin) begin
            r_state     <= S_FINISH;
            r_done      <= 1'b1;
            r_rx_enable <= 1'b0;
            r_result    <= tr_first_error(r_res_acc, w_err_code);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mil_bc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mil_bc_sequencer
//  Description : Directed self-checking bench for mil_bc_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mil_bc_sequencer;
   import milStd1553::*;

   localparam int RESP = 1400;
   localparam int GAP  = 400;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_word = 16'h0;
   logic        txd_valid = 1'b0;
   logic        txd_ready;
   logic [15:0] txd_data = 16'h0;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic [15:0] tx_word;
   logic [1:0]  tx_type;
   logic        tx_idle = 1'b1;
   logic        rx_enable;
   logic        rx_req = 1'b0;
   logic [15:0] rx_word = 16'h0;
   logic [1:0]  rx_type = 2'd0;
   logic        rxd_valid;
   logic [15:0] rxd_data;
   logic        done;
   logic [2:0]  result;
   logic [15:0] status;
   logic        busy;

   always #5 clk = ~clk;

   mil_bc_sequencer #(
      .RESP_TIMEOUT (RESP),
      .GAP_TIMEOUT  (GAP),
      .CNT_W        (11)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_word  (cmd_word),
      .txd_valid (txd_valid),
      .txd_ready (txd_ready),
      .txd_data  (txd_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_word   (tx_word),
      .tx_type   (tx_type),
      .tx_idle   (tx_idle),
      .rx_enable (rx_enable),
      .rx_req    (rx_req),
      .rx_word   (rx_word),
      .rx_type   (rx_type),
      .rxd_valid (rxd_valid),
      .rxd_data  (rxd_data),
      .done      (done),
      .result    (result),
      .status    (status),
      .busy      (busy)
   );

   int          n_vec  = 0;
   int          n_miss = 0;
   int          done_cnt = 0;
   logic        txd_pop = 1'b0;
   logic [15:0] txw_q[$];
   logic [1:0]  txt_q[$];
   logic [15:0] rxd_q[$];
   logic [15:0] txd_src[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Observe transfers half a cycle after the active edge
   always @(negedge clk) begin
      if (tx_valid && tx_ready) begin
         txw_q.push_back(tx_word);
         txt_q.push_back(tx_type);
      end
      if (txd_ready) txd_pop = 1'b1;
      if (rxd_valid) rxd_q.push_back(rxd_data);
      if (done) done_cnt++;
   end

   task automatic tick(input int n);
      logic [15:0] tmp;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (txd_pop) begin
            if (txd_src.size() != 0) tmp = txd_src.pop_front();
            txd_pop = 1'b0;
         end
         txd_valid = (txd_src.size() != 0);
         if (txd_valid) txd_data = txd_src[0];
         else           txd_data = 16'h0;
      end
   endtask

   task automatic clr();
      txw_q.delete();
      txt_q.delete();
      rxd_q.delete();
   endtask

   task automatic issue(input logic [15:0] w);
      int k;
      k = 0;
      while (!cmd_ready && k < 100) begin
         tick(1);
         k++;
      end
      chk("cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_word  = w;
      tick(1);
      cmd_valid = 1'b0;
   endtask

   task automatic push_rx(input logic [15:0] w, input logic [1:0] t);
      rx_req  = 1'b1;
      rx_word = w;
      rx_type = t;
      tick(1);
      rx_req  = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int start;
      int k;
      start = done_cnt;
      k = 0;
      while (done_cnt == start && k < bound) begin
         tick(1);
         k++;
      end
      chk({tag, "_done"}, done_cnt - start, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int start;

      // Reset state
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_rx_enable", rx_enable, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, TR_OK);
      chk("rst_status", status, 16'h0000);

      // BC->RT, addr 5, sa 1, N=2, status after 500 clocks
      clr();
      txd_src.push_back(16'h1234);
      txd_src.push_back(16'h5678);
      issue(16'h2822);
      tick(10);
      chk("t1_rx_enable", rx_enable, 1);
      tick(500);
      push_rx(16'h2800, WSTATUS);
      wait_done("t1", 50);
      chk("t1_result", result, TR_OK);
      chk("t1_status", status, 16'h2800);
      chk("t1_ntx", txw_q.size(), 3);
      if (txw_q.size() == 3) begin
         chk("t1_w0", txw_q[0], 16'h2822);
         chk("t1_w1", txw_q[1], 16'h1234);
         chk("t1_w2", txw_q[2], 16'h5678);
         chk("t1_t0", txt_q[0], WCOMMAND);
         chk("t1_t1", txt_q[1], WDATA);
      end
      chk("t1_rx_enable_off", rx_enable, 0);

      // RT->BC, N=3
      clr();
      issue(16'h2C23);
      tick(3);
      push_rx(16'h2800, WSTATUS);
      tick(5);
      push_rx(16'h000A, WDATA);
      push_rx(16'h000B, WDATA);
      push_rx(16'h000C, WDATA);
      wait_done("t2", 20);
      chk("t2_result", result, TR_OK);
      chk("t2_nrx", rxd_q.size(), 3);
      if (rxd_q.size() == 3) begin
         chk("t2_d0", rxd_q[0], 16'h000A);
         chk("t2_d1", rxd_q[1], 16'h000B);
         chk("t2_d2", rxd_q[2], 16'h000C);
      end

      // No response: done exactly RESP+1 clocks after tx_idle is seen
      clr();
      tx_idle = 1'b0;
      issue(16'h2C21);
      tick(5);
      chk("t3_busy", busy, 1);
      chk("t3_rx_enable_wait", rx_enable, 0);
      start = done_cnt;
      tx_idle = 1'b1;
      tick(1);
      n = 0;
      while (!done && n < 3000) begin
         tick(1);
         n++;
      end
      chk("t3_latency", n, RESP + 1);
      chk("t3_result", result, TR_TIMEOUT);
      tick(2);
      chk("t3_ndone", done_cnt - start, 1);

      // Status from wrong RT
      clr();
      issue(16'h2C21);
      tick(3);
      push_rx(16'h3000, WSTATUS);
      wait_done("t4a", 10);
      chk("t4a_result", result, TR_BADADDR);
      chk("t4a_status", status, 16'h3000);

      // Status with bit 9 set arrives as WCOMMAND: accepted, data phase still runs
      clr();
      issue(16'h2C21);
      tick(3);
      push_rx(16'h2A00, WCOMMAND);
      tick(2);
      chk("t4b_busy", busy, 1);
      chk("t4b_rx_enable", rx_enable, 1);
      push_rx(16'h00D1, WDATA);
      wait_done("t4b", 10);
      chk("t4b_result", result, TR_BADSTATUS);
      chk("t4b_status", status, 16'h2A00);
      chk("t4b_nrx", rxd_q.size(), 1);

      // Mode code (sa 0): no data phase even with a nonzero count field
      clr();
      issue(16'h2C02);
      tick(3);
      push_rx(16'h2800, WSTATUS);
      wait_done("t4c", 10);
      chk("t4c_result", result, TR_OK);
      chk("t4c_nrx", rxd_q.size(), 0);

      // RT->BC N=2, second word parity error
      clr();
      issue(16'h2C22);
      tick(3);
      push_rx(16'h2800, WSTATUS);
      push_rx(16'h0011, WDATA);
      push_rx(16'hBEEF, WERROR);
      wait_done("t5a", 10);
      chk("t5a_result", result, TR_PARITY);
      chk("t5a_nrx", rxd_q.size(), 1);

      // RT->BC N=2, second word never arrives
      clr();
      issue(16'h2C22);
      tick(3);
      push_rx(16'h2800, WSTATUS);
      push_rx(16'h0022, WDATA);
      wait_done("t5b", GAP + 50);
      chk("t5b_result", result, TR_TIMEOUT);
      chk("t5b_nrx", rxd_q.size(), 1);

      // BC->RT N=3, source runs dry after the first word
      clr();
      txd_src.push_back(16'h1111);
      issue(16'h2823);
      wait_done("t6", 30);
      chk("t6_result", result, TR_UNDERFLOW);
      chk("t6_ntx", txw_q.size(), 2);
      if (txw_q.size() == 2) chk("t6_w1", txw_q[1], 16'h1111);
      chk("t6_status_held", status, 16'h2800);

      // Reset while waiting for status: abort, no done
      clr();
      issue(16'h2C21);
      tick(10);
      chk("t7_rx_enable", rx_enable, 1);
      start = done_cnt;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      chk("t7_busy", busy, 0);
      chk("t7_rx_enable_off", rx_enable, 0);
      chk("t7_cmd_ready", cmd_ready, 1);
      chk("t7_result", result, TR_OK);
      tick(20);
      chk("t7_ndone", done_cnt - start, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
